// File: rtl/traffic_phase_sequencer.sv
// traffic_phase_sequencer: sequences main/side/walk lamps and arms the shared interval timer once per phase.
// Latency: an expiry pulse seen in WAIT updates the lamps and raises start_timer at the edge that samples it.
// Backpressure: none; a 1 Hz watchdog latches a flashing fault if the timer never reports expiry.
module traffic_phase_sequencer #(
   parameter logic [3:0] T_BASE = 4'd6,
   parameter logic [3:0] T_EXT  = 4'd3,
   parameter logic [3:0] T_YEL  = 4'd2,
   parameter logic [3:0] T_WALK = 4'd4
) (
   input  logic       i_clk,
   input  logic       i_reset_n,
   input  logic       i_onehz_enable,
   input  logic       i_car_side,
   input  logic       i_walk_req,
   input  logic       i_expired,
   output logic [3:0] o_timer_value,
   output logic       o_start_timer,
   output logic [2:0] o_main_lights,
   output logic [2:0] o_side_lights,
   output logic       o_walk_light,
   output logic       o_fault,
   output logic [2:0] o_phase
);

   typedef enum logic [2:0] {
      ST_ALL_RED = 3'd0,
      ST_MG      = 3'd1,
      ST_MY      = 3'd2,
      ST_WALK    = 3'd3,
      ST_SG      = 3'd4,
      ST_SGX     = 3'd5,
      ST_SY      = 3'd6,
      ST_FAULT   = 3'd7
   } state_t;

   state_t     r_state, w_state_nxt;
   logic       r_init;                 // ALL_RED ARM still owed after reset release
   logic       r_start, w_start_nxt;   // high during the ARM cycle of a state
   logic [3:0] r_tv, w_tv_nxt;
   logic       r_pend, w_pend_nxt;
   logic [4:0] r_tick, w_tick_nxt;
   logic       r_flash, w_flash_nxt;
   logic [2:0] r_main, w_main_nxt;
   logic [2:0] r_side, w_side_nxt;
   logic       r_walk, w_walk_nxt;
   logic       r_fault;
   logic       w_trip;

   // Interval loaded into the timer when a state is armed.
   function automatic logic [3:0] f_interval(input state_t s);
      case (s)
         ST_MG, ST_SG: f_interval = T_BASE;
         ST_SGX:       f_interval = T_EXT;
         ST_WALK:      f_interval = T_WALK;
         default:      f_interval = T_YEL;
      endcase
   endfunction

   // Next state, timer control, watchdog and flash phase.
   always_comb begin
      w_state_nxt = r_state;
      w_start_nxt = 1'b0;
      w_tv_nxt    = r_tv;
      w_tick_nxt  = r_tick;
      w_flash_nxt = r_flash;
      w_trip      = (r_tick > ({1'b0, r_tv} + 5'd2));
      if (r_init) begin
         w_start_nxt = 1'b1;
         w_tick_nxt  = 5'd0;
      end else if (r_state == ST_FAULT) begin
         if (i_onehz_enable) begin
            w_flash_nxt = ~r_flash;
         end
      end else if (r_start) begin
         // ARM cycle: expiry is ignored, watchdog restarts.
         w_tick_nxt = 5'd0;
      end else if (i_expired) begin
         case (r_state)
            ST_ALL_RED: w_state_nxt = ST_MG;
            ST_MG:      w_state_nxt = (i_car_side || r_pend) ? ST_MY : ST_MG;
            ST_MY:      w_state_nxt = r_pend ? ST_WALK : ST_SG;
            ST_WALK:    w_state_nxt = i_car_side ? ST_SG : ST_MG;
            ST_SG:      w_state_nxt = i_car_side ? ST_SGX : ST_SY;
            ST_SGX:     w_state_nxt = ST_SY;
            ST_SY:      w_state_nxt = ST_MG;
            default:    w_state_nxt = r_state;
         endcase
         w_start_nxt = 1'b1;
         w_tv_nxt    = f_interval(w_state_nxt);
         w_tick_nxt  = 5'd0;
      end else if (w_trip) begin
         w_state_nxt = ST_FAULT;
         w_flash_nxt = 1'b1;
      end else if (i_onehz_enable && (r_tick != 5'd31)) begin
         w_tick_nxt = r_tick + 5'd1;
      end
   end

   // Walk request latch: any request while WALK is active is absorbed.
   always_comb begin
      w_pend_nxt = r_pend;
      if (r_state == ST_WALK) begin
         w_pend_nxt = 1'b0;
      end else if (i_walk_req && (r_state != ST_FAULT)) begin
         w_pend_nxt = 1'b1;
      end
   end

   // Lamp decode from the upcoming state so the lamp outputs come straight from flops.
   always_comb begin
      w_main_nxt = 3'b100;
      w_side_nxt = 3'b100;
      w_walk_nxt = 1'b0;
      case (w_state_nxt)
         ST_MG:          w_main_nxt = 3'b001;
         ST_MY:          w_main_nxt = 3'b010;
         ST_SG, ST_SGX:  w_side_nxt = 3'b001;
         ST_SY:          w_side_nxt = 3'b010;
         ST_WALK:        w_walk_nxt = 1'b1;
         ST_FAULT: begin
            w_main_nxt = {1'b0, w_flash_nxt, 1'b0};
            w_side_nxt = {w_flash_nxt, 2'b00};
         end
         default: begin
            w_main_nxt = 3'b100;
            w_side_nxt = 3'b100;
         end
      endcase
   end

   // State and output registers, all cleared asynchronously.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_state <= ST_ALL_RED;
         r_init  <= 1'b1;
         r_start <= 1'b0;
         r_tv    <= T_YEL;
         r_pend  <= 1'b0;
         r_tick  <= 5'd0;
         r_flash <= 1'b1;
         r_main  <= 3'b100;
         r_side  <= 3'b100;
         r_walk  <= 1'b0;
         r_fault <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_init  <= 1'b0;
         r_start <= w_start_nxt;
         r_tv    <= w_tv_nxt;
         r_pend  <= w_pend_nxt;
         r_tick  <= w_tick_nxt;
         r_flash <= w_flash_nxt;
         r_main  <= w_main_nxt;
         r_side  <= w_side_nxt;
         r_walk  <= w_walk_nxt;
         r_fault <= (w_state_nxt == ST_FAULT);
      end
   end

   assign o_timer_value = r_tv;
   assign o_start_timer = r_start;
   assign o_main_lights = r_main;
   assign o_side_lights = r_side;
   assign o_walk_light  = r_walk;
   assign o_fault       = r_fault;
   assign o_phase       = r_state;

endmodule
